// File: rtl/laser_cover_checker.sv
// laser_cover_checker: rescoring stage for the two-circle laser-placement solver.
// It snoops the solver's 40-point frame into ping-pong banks. On DONE it latches both
// centres and recounts the coverage of each circle and of the pair.
// Latency: 41 cycles from the DONE edge to RESULT_VALID. Backpressure: none. Points
// that arrive while the write bank is full, and DONEs that cannot start a scan, are
// dropped and flagged on ERR.
// Ports: CLK/RST (async, active-high); IN_VALID/X/Y frame point; DONE/C1X/C1Y/C2X/C2Y
// result strobe and centres; RESULT_VALID/CNT1/CNT2/TOTAL counts; BUSY scan in
// progress; ERR one-cycle drop pulse.
module laser_cover_checker (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       DONE,
    input  logic [3:0] C1X,
    input  logic [3:0] C1Y,
    input  logic [3:0] C2X,
    input  logic [3:0] C2Y,
    output logic       RESULT_VALID,
    output logic [5:0] CNT1,
    output logic [5:0] CNT2,
    output logic [5:0] TOTAL,
    output logic       BUSY,
    output logic       ERR
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;
    localparam logic [5:0] LAST_IDX  = 6'd39;

    // Squared-distance test, radius 4.
    // Squares are 8 bits and the sum is 9 bits, so no term can wrap.
    function automatic logic covers(input logic [3:0] px, input logic [3:0] py,
                                    input logic [3:0] cx, input logic [3:0] cy);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [7:0] sx;
        logic [7:0] sy;
        logic [8:0] sum;
        dx  = (px >= cx) ? (px - cx) : (cx - px);
        dy  = (py >= cy) ? (py - cy) : (cy - py);
        sx  = {4'd0, dx} * {4'd0, dx};
        sy  = {4'd0, dy} * {4'd0, dy};
        sum = {1'b0, sx} + {1'b0, sy};
        return (sum <= 9'd16);
    endfunction

    logic [1:0] state_q, state_d;
    logic       wbank_q, wbank_d;
    logic [5:0] wptr_q, wptr_d;
    logic       rbank_q, rbank_d;
    logic [1:0] full_q, full_d;
    logic [5:0] idx_q, idx_d;
    logic [3:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
    logic [5:0] acc1_q, acc1_d, acc2_q, acc2_d, acct_q, acct_d;
    logic [5:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, total_q, total_d;
    logic       result_valid_q, result_valid_d;
    logic       err_q, err_d;

    logic [7:0] buf_mem [2][40];
    logic       wr_en;
    logic [7:0] rd_dat;
    logic       in1;
    logic       in2;

    // Point storage carries no reset; the full flags alone say what is valid.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            buf_mem[wbank_q][wptr_q] <= {X, Y};
        end
    end

    assign rd_dat = buf_mem[rbank_q][idx_q];
    assign in1    = covers(rd_dat[7:4], rd_dat[3:0], c1x_q, c1y_q);
    assign in2    = covers(rd_dat[7:4], rd_dat[3:0], c2x_q, c2y_q);

    always_comb begin
        state_d        = state_q;
        wbank_d        = wbank_q;
        wptr_d         = wptr_q;
        rbank_d        = rbank_q;
        full_d         = full_q;
        idx_d          = idx_q;
        c1x_d          = c1x_q;
        c1y_d          = c1y_q;
        c2x_d          = c2x_q;
        c2y_d          = c2y_q;
        acc1_d         = acc1_q;
        acc2_d         = acc2_q;
        acct_d         = acct_q;
        cnt1_d         = cnt1_q;
        cnt2_d         = cnt2_q;
        total_d        = total_q;
        result_valid_d = 1'b0;
        err_d          = 1'b0;
        wr_en          = 1'b0;

        // Capture side. It runs independently of the scan, so the next frame can
        // load while the current one is being scored.
        if (IN_VALID) begin
            if (full_q[wbank_q]) begin
                err_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (wptr_q == LAST_IDX) begin
                    full_d[wbank_q] = 1'b1;
                    wptr_d          = 6'd0;
                    wbank_d         = ~wbank_q;
                end else begin
                    wptr_d = wptr_q + 6'd1;
                end
            end
        end

        // Scan side. It reads the registered full flag, so a bank that
        // completes on the same edge as DONE is not yet scannable. The clear
        // below targets rbank, which can never equal a bank being set by
        // capture on the same edge.
        case (state_q)
            ST_IDLE: begin
                if (DONE) begin
                    if (full_q[rbank_q]) begin
                        state_d = ST_SCAN;
                        c1x_d   = C1X;
                        c1y_d   = C1Y;
                        c2x_d   = C2X;
                        c2y_d   = C2Y;
                        acc1_d  = 6'd0;
                        acc2_d  = 6'd0;
                        acct_d  = 6'd0;
                        idx_d   = 6'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (DONE) begin
                    err_d = 1'b1;
                end
                acc1_d = acc1_q + {5'd0, in1};
                acc2_d = acc2_q + {5'd0, in2};
                acct_d = acct_q + {5'd0, (in1 | in2)};
                idx_d  = idx_q + 6'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_REPORT;
                    idx_d   = 6'd0;
                end
            end
            ST_REPORT: begin
                if (DONE) begin
                    err_d = 1'b1;
                end
                cnt1_d          = acc1_q;
                cnt2_d          = acc2_q;
                total_d         = acct_q;
                result_valid_d  = 1'b1;
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= ST_IDLE;
            wbank_q        <= 1'b0;
            wptr_q         <= 6'd0;
            rbank_q        <= 1'b0;
            full_q         <= 2'b00;
            idx_q          <= 6'd0;
            c1x_q          <= 4'd0;
            c1y_q          <= 4'd0;
            c2x_q          <= 4'd0;
            c2y_q          <= 4'd0;
            acc1_q         <= 6'd0;
            acc2_q         <= 6'd0;
            acct_q         <= 6'd0;
            cnt1_q         <= 6'd0;
            cnt2_q         <= 6'd0;
            total_q        <= 6'd0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wbank_q        <= wbank_d;
            wptr_q         <= wptr_d;
            rbank_q        <= rbank_d;
            full_q         <= full_d;
            idx_q          <= idx_d;
            c1x_q          <= c1x_d;
            c1y_q          <= c1y_d;
            c2x_q          <= c2x_d;
            c2y_q          <= c2y_d;
            acc1_q         <= acc1_d;
            acc2_q         <= acc2_d;
            acct_q         <= acct_d;
            cnt1_q         <= cnt1_d;
            cnt2_q         <= cnt2_d;
            total_q        <= total_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
        end
    end

    assign RESULT_VALID = result_valid_q;
    assign CNT1         = cnt1_q;
    assign CNT2         = cnt2_q;
    assign TOTAL        = total_q;
    assign BUSY         = (state_q != ST_IDLE);
    assign ERR          = err_q;

endmodule

// File: tb/tb_laser_cover_checker.sv
// tb_laser_cover_checker: directed and randomized checks of laser_cover_checker.
// Expected counts come from a Euclidean-distance model over stored frame arrays.
// ERR and RESULT_VALID pulses are counted by a monitor at the rising edge.
module tb_laser_cover_checker;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IN_VALID;
    logic [3:0] X, Y;
    logic       DONE;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic       RESULT_VALID;
    logic [5:0] CNT1, CNT2, TOTAL;
    logic       BUSY;
    logic       ERR;

    laser_cover_checker dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .X(X), .Y(Y), .DONE(DONE),
        .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
        .RESULT_VALID(RESULT_VALID), .CNT1(CNT1), .CNT2(CNT2), .TOTAL(TOTAL),
        .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int err_seen = 0;
    int rv_seen = 0;
    int t0;
    int px [3][40];
    int py [3][40];
    int e0, r0, x1, x2, xt, nres;

    // Pre-edge values are sampled here, so each pulse is counted exactly once.
    always @(posedge CLK) begin
        cyc++;
        if (ERR === 1'b1) err_seen++;
        if (RESULT_VALID === 1'b1) rv_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit covers(input int x, input int y, input int cx, input int cy);
        return ((x - cx) * (x - cx) + (y - cy) * (y - cy)) <= 16;
    endfunction

    task automatic score(input int s, input int a1x, input int a1y, input int a2x,
                         input int a2y, output int e1, output int e2, output int et);
        e1 = 0; e2 = 0; et = 0;
        for (int i = 0; i < 40; i++) begin
            bit a, b;
            a = covers(px[s][i], py[s][i], a1x, a1y);
            b = covers(px[s][i], py[s][i], a2x, a2y);
            if (a) e1++;
            if (b) e2++;
            if (a || b) et++;
        end
    endtask

    task automatic rand_centres();
        C1X = 4'($urandom_range(0, 15)); C1Y = 4'($urandom_range(0, 15));
        C2X = 4'($urandom_range(0, 15)); C2Y = 4'($urandom_range(0, 15));
    endtask

    // Random points scattered around (cx,cy), so coverage varies across the radius.
    task automatic fill_near(input int s, input int cx, input int cy);
        for (int i = 0; i < 40; i++) begin
            int vx, vy;
            vx = cx + int'($urandom_range(0, 12)) - 6;
            vy = cy + int'($urandom_range(0, 12)) - 6;
            px[s][i] = (vx < 0) ? 0 : (vx > 15) ? 15 : vx;
            py[s][i] = (vy < 0) ? 0 : (vy > 15) ? 15 : vy;
        end
    endtask

    task automatic set_all(input int s, input int x, input int y, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            px[s][i] = x; py[s][i] = y;
        end
    endtask

    task automatic load_frame(input int s, input bit gaps, input bit done_last);
        for (int i = 0; i < 40; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge CLK); IN_VALID = 1'b0;
            end
            @(negedge CLK);
            IN_VALID = 1'b1;
            X = 4'(px[s][i]);
            Y = 4'(py[s][i]);
            if (done_last && i == 39) begin
                DONE = 1'b1; t0 = cyc + 1;
            end
        end
        @(negedge CLK);
        IN_VALID = 1'b0; DONE = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge CLK); DONE = 1'b1; t0 = cyc + 1;
        @(negedge CLK); DONE = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int e1, input int e2, input int et);
        bit got;
        got = 1'b0;
        check({tag, "_busy"}, 32'(BUSY), 1);
        for (int k = 0; k < 60 && !got; k++) begin
            if (RESULT_VALID === 1'b1) got = 1'b1;
            else @(negedge CLK);
        end
        check({tag, "_found"}, 32'(got), 1);
        if (got) begin
            check({tag, "_latency"}, 32'(cyc - t0), 41);
            check({tag, "_cnt1"}, 32'(CNT1), 32'(e1));
            check({tag, "_cnt2"}, 32'(CNT2), 32'(e2));
            check({tag, "_total"}, 32'(TOTAL), 32'(et));
            @(negedge CLK);
            check({tag, "_pulse_end"}, 32'(RESULT_VALID), 0);
            check({tag, "_hold"}, 32'(CNT1), 32'(e1));
            check({tag, "_idle"}, 32'(BUSY), 0);
        end
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; DONE = 1'b0; X = 4'd0; Y = 4'd0;
        C1X = 4'd0; C1Y = 4'd0; C2X = 4'd0; C2Y = 4'd0;
        repeat (3) @(negedge CLK);
        check("rst_rv", 32'(RESULT_VALID), 0);
        check("rst_cnt1", 32'(CNT1), 0);
        check("rst_cnt2", 32'(CNT2), 0);
        check("rst_total", 32'(TOTAL), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_err", 32'(ERR), 0);
        RST = 1'b0;
        @(negedge CLK);

        // DONE with no complete frame: one ERR, no result.
        e0 = err_seen; r0 = rv_seen;
        pulse_done();
        repeat (5) @(negedge CLK);
        check("early_done_err", 32'(err_seen - e0), 1);
        check("early_done_rv", 32'(rv_seen - r0), 0);
        check("early_done_busy", 32'(BUSY), 0);

        // Full coverage by circle 1.
        set_all(0, 5, 5, 0, 40);
        load_frame(0, 1'b0, 1'b0);
        C1X = 4'd5; C1Y = 4'd5; C2X = 4'd12; C2Y = 4'd12;
        pulse_done();
        wait_result("coverage", 40, 0, 40);

        // Radius boundary: (4,1) offset gives 17 and is outside.
        set_all(0, 8, 10, 0, 10); set_all(0, 9, 10, 10, 20);
        set_all(0, 7, 11, 20, 30); set_all(0, 10, 9, 30, 40);
        load_frame(0, 1'b1, 1'b0);
        C1X = 4'd6; C1Y = 4'd8; C2X = 4'd0; C2Y = 4'd0;
        pulse_done();
        wait_result("radius", 30, 0, 30);

        // Overlap: both circles cover every point.
        set_all(0, 4, 4, 0, 20); set_all(0, 6, 4, 20, 40);
        load_frame(0, 1'b0, 1'b0);
        C1X = 4'd3; C1Y = 4'd4; C2X = 4'd7; C2Y = 4'd4;
        pulse_done();
        wait_result("overlap", 40, 40, 40);

        // Randomized frames and centres scored against the model.
        for (int r = 0; r < 6; r++) begin
            rand_centres();
            fill_near(0, int'(C1X), int'(C1Y));
            load_frame(0, 1'b1, 1'b0);
            score(0, int'(C1X), int'(C1Y), int'(C2X), int'(C2Y), x1, x2, xt);
            pulse_done();
            wait_result("random", x1, x2, xt);
        end

        // Ping-pong: the next frame loads during the scan, the second DONE comes at t0+50.
        rand_centres();
        fill_near(0, int'(C1X), int'(C1Y));
        set_all(1, 0, 0, 0, 40);
        load_frame(0, 1'b1, 1'b0);
        e0 = err_seen; nres = 0;
        @(negedge CLK); DONE = 1'b1; t0 = cyc + 1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            if (RESULT_VALID === 1'b1) begin
                nres++;
                if (nres == 1) begin
                    check("pp1_latency", 32'(cyc - t0), 41);
                    check("pp1_cnt1", 32'(CNT1), 32'(x1));
                    check("pp1_cnt2", 32'(CNT2), 32'(x2));
                    check("pp1_total", 32'(TOTAL), 32'(xt));
                end else begin
                    check("pp2_latency", 32'(cyc - t0), 91);
                    check("pp2_cnt1", 32'(CNT1), 40);
                    check("pp2_cnt2", 32'(CNT2), 32'(x2));
                    check("pp2_total", 32'(TOTAL), 40);
                end
            end
            // First-scan expectations are computed before its centres are overwritten.
            if (k == 1) score(0, int'(C1X), int'(C1Y), int'(C2X), int'(C2Y), x1, x2, xt);
            DONE = (k == 50);
            IN_VALID = (k <= 40);
            X = 4'd0; Y = 4'd0;
            if (k == 50) begin
                C1X = 4'd0; C1Y = 4'd0;
                C2X = 4'($urandom_range(0, 15)); C2Y = 4'($urandom_range(0, 15));
                score(1, 0, 0, int'(C2X), int'(C2Y), x1, x2, xt);
            end
        end
        IN_VALID = 1'b0; DONE = 1'b0;
        check("pp_results", 32'(nres), 2);
        check("pp_no_err", 32'(err_seen - e0), 0);

        // Third frame while both banks are full: 40 drops, then both stored frames intact.
        fill_near(0, 4, 4); fill_near(1, 11, 11); fill_near(2, 7, 7);
        load_frame(0, 1'b0, 1'b0);
        load_frame(1, 1'b1, 1'b0);
        e0 = err_seen; r0 = rv_seen;
        load_frame(2, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        check("overflow_err", 32'(err_seen - e0), 40);
        check("overflow_rv", 32'(rv_seen - r0), 0);
        rand_centres();
        score(0, int'(C1X), int'(C1Y), int'(C2X), int'(C2Y), x1, x2, xt);
        pulse_done();
        wait_result("overflow_a", x1, x2, xt);
        C1X = 4'd11; C1Y = 4'd11;
        score(1, int'(C1X), int'(C1Y), int'(C2X), int'(C2Y), x1, x2, xt);
        pulse_done();
        wait_result("overflow_b", x1, x2, xt);

        // DONE on the same edge as the 40th write: rejected, then accepted next time.
        rand_centres();
        fill_near(0, int'(C2X), int'(C2Y));
        e0 = err_seen; r0 = rv_seen;
        load_frame(0, 1'b0, 1'b1);
        repeat (50) @(negedge CLK);
        check("same_edge_err", 32'(err_seen - e0), 1);
        check("same_edge_rv", 32'(rv_seen - r0), 0);
        score(0, int'(C1X), int'(C1Y), int'(C2X), int'(C2Y), x1, x2, xt);
        pulse_done();
        wait_result("same_edge_retry", x1, x2, xt);

        // Reset mid-scan with a partial frame in capture.
        fill_near(0, 8, 8);
        load_frame(0, 1'b0, 1'b0);
        C1X = 4'd8; C1Y = 4'd8;
        pulse_done();
        while (cyc < t0 + 20) begin
            @(negedge CLK);
            IN_VALID = 1'b1; X = 4'($urandom_range(0, 15)); Y = 4'($urandom_range(0, 15));
        end
        IN_VALID = 1'b0;
        RST = 1'b1;
        #1;
        check("mid_rst_rv", 32'(RESULT_VALID), 0);
        check("mid_rst_cnt1", 32'(CNT1), 0);
        check("mid_rst_cnt2", 32'(CNT2), 0);
        check("mid_rst_total", 32'(TOTAL), 0);
        check("mid_rst_busy", 32'(BUSY), 0);
        check("mid_rst_err", 32'(ERR), 0);
        r0 = rv_seen;
        @(negedge CLK); RST = 1'b0;
        repeat (45) @(negedge CLK);
        check("mid_rst_no_rv", 32'(rv_seen - r0), 0);
        rand_centres();
        fill_near(2, int'(C1X), int'(C1Y));
        load_frame(2, 1'b1, 1'b0);
        score(2, int'(C1X), int'(C1Y), int'(C2X), int'(C2Y), x1, x2, xt);
        pulse_done();
        wait_result("after_rst", x1, x2, xt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/laser_cover_checker.md
# laser_cover_checker

Downstream checking stage for the two-circle laser-placement solver. It snoops the solver's 40-point input frame, captures the two circle centres when the solver pulses DONE, and recounts how many of the 40 points each circle covers and how many the pair covers together. The block uses ping-pong point buffers, so the solver's next frame can load while the current frame is being scored.

## Interface
- No parameters; the frame size is fixed at 40 points on a 16x16 grid.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- IN_VALID  in  1  X/Y carry one frame point this cycle; driven in step with the solver's load.
- X  in  4  point x coordinate.
- Y  in  4  point y coordinate.
- DONE  in  1  solver result strobe; C1X/C1Y/C2X/C2Y are valid while it is high.
- C1X, C1Y, C2X, C2Y  in  4 each  circle centres.
- RESULT_VALID  out  1  one-cycle pulse; the count outputs are new.
- CNT1  out  6  number of points covered by circle 1 (0..40).
- CNT2  out  6  number of points covered by circle 2.
- TOTAL  out  6  number of points covered by circle 1 or circle 2.
- BUSY  out  1  a scan is in progress.
- ERR  out  1  one-cycle pulse; a DONE or a point was dropped.

## Operation
- Coverage rule: dx=|px-cx| and dy=|py-cy| are 4-bit values. A point is covered when dx*dy... specifically when dx*dx+dy*dy <= 16.
  - Equivalent form: dx+dy<=4, or (dx,dy) is (3,2) or (2,3).
  - Compute the squares at 8 bits and compare at 9 bits. Nothing saturates.
- Buffers: two banks of 40 entries, each entry 8 bits {x,y}. Each bank has a full flag.
  - The write side holds wbank (1 bit) and wptr (6 bits).
  - The read side holds rbank (1 bit).
- Capture side:
  - IN_VALID with full[wbank]=0: write {X,Y} to bank[wbank][wptr] and increment wptr.
  - On the 40th write (wptr==39): set full[wbank], clear wptr, toggle wbank.
  - Gaps in IN_VALID are allowed; wptr holds across them.
  - IN_VALID with full[wbank]=1: the point is dropped and ERR pulses.
- Scan FSM states: IDLE, SCAN, REPORT.
  - IDLE -> SCAN: DONE=1 and full[rbank]=1, using registered flags. On this edge, latch C1X..C2Y, clear the three accumulators and set idx=0.
  - DONE in IDLE with full[rbank]=0: ERR pulses and the state stays IDLE.
  - DONE in SCAN or REPORT: ignored; ERR pulses.
  - SCAN: each cycle evaluate entry idx of bank rbank against both latched centres.
    - Add in1 to acc1 and in2 to acc2.
    - Add (in1|in2) to acct.
    - Increment idx. After idx==39 is processed, go to REPORT.
  - REPORT (one cycle): copy the accumulators to CNT1/CNT2/TOTAL, assert RESULT_VALID, clear full[rbank], toggle rbank, return to IDLE.
- A full-flag set (capture) and clear (scan end) on the same edge touch different banks and never conflict. If both target the same bank, the clear applies to rbank and the set to wbank; this can only happen when rbank==wbank, which is impossible while that bank is full.
- BUSY=1 in SCAN and REPORT.

## Timing
- Reset values: RESULT_VALID=0, CNT1=CNT2=TOTAL=0, BUSY=0, ERR=0. Also wptr=0, wbank=rbank=0, full=00, state IDLE. Buffer contents are don't-care.
- DONE sampled at edge t0 starts the scan:
  - entry 0 is evaluated in the cycle after t0;
  - entry 39 is evaluated in cycle t0+40;
  - RESULT_VALID is high from edge t0+41 until edge t0+42;
  - the count outputs hold their values until the next REPORT.
- Latency from DONE to result is 41 cycles. A new DONE is accepted from edge t0+42 onward.
- The 40th write of a frame and DONE on the same edge: DONE sees the pre-edge full flag, so a bank that completes on that edge is not yet scannable and ERR pulses.
- Capture continues during SCAN into the other bank, so the solver's next 40-point load, starting the cycle after DONE, is never dropped.
- ERR is registered: it is high for the cycle after the offending edge.
- RST asserted mid-scan or mid-capture: all state clears immediately, no RESULT_VALID is produced, and the partial frame is discarded.

## Test plan
- Coverage: 40 points at (5,5), DONE with C1=(5,5) and C2=(12,12). Required: RESULT_VALID 41 cycles after DONE with CNT1=40, CNT2=0, TOTAL=40.
- Radius boundary: 10 points each at (8,10), (9,10), (7,11) and (10,9), with C1=(6,8) and C2=(0,0). Offsets from C1 are (2,2), (3,2), (1,3) and (4,1). Required: CNT1=30, CNT2=0, TOTAL=30, because (4,1) gives 17, which exceeds 16.
- Overlap: 20 points at (4,4) and 20 at (6,4), with C1=(3,4) and C2=(7,4). Required: CNT1=40, CNT2=40, TOTAL=40.
- Ping-pong: the next frame (all (0,0)) loads starting the cycle after the first DONE. The second DONE arrives at t0+50 with C1=(0,0). Required: no ERR, the first result is correct, and the second result has CNT1=40.
- Errors:
  - DONE before any frame completes: ERR pulse, no RESULT_VALID.
  - A third frame arriving while both banks are full: each of its 40 points pulses ERR.
- Reset: RST asserted at t0+20 during a scan. Required: all outputs are 0, no RESULT_VALID, and a fresh frame plus DONE then scores correctly.
